mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Shares the single-word main-memory port between the instruction-cache refill path and the data-cache refill/write-through path. Turns each line-refill request into LINE_WIDTH sequential word reads and forwards data-cache word writes. Arbitrates round-robin between the two caches, with data-cache writes ahead of data-cache reads. Sits between both caches and the memory controller.

## Interface
- ADDR_WIDTH, 16, word address width
- DATA_WIDTH, 32, word width
- LINE_WIDTH, 4, words per cache line (power of 2, ≥2)
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- i_rd_en  in  1  icache line-refill request
- i_rd_addr  in  ADDR_WIDTH  icache refill address; offset bits ignored
- i_rd_data  out  DATA_WIDTH  refill word
- i_rd_valid  out  1  i_rd_data valid this cycle
- d_rd_en  in  1  dcache line-refill request
- d_rd_addr  in  ADDR_WIDTH  dcache refill address; offset bits ignored
- d_rd_data  out  DATA_WIDTH  refill word
- d_rd_valid  out  1  d_rd_data valid this cycle
- d_wr_en  in  1  dcache word-write request, held until d_wr_rdy
- d_wr_addr  in  ADDR_WIDTH  write address
- d_wr_data  in  DATA_WIDTH  write data
- d_wr_sel  in  DATA_WIDTH/8  byte enables
- d_wr_rdy  out  1  one-cycle pulse: write accepted by memory
- mem_req  out  1  memory request, held until mem_ack
- mem_we  out  1  1 = write, 0 = read
- mem_addr  out  ADDR_WIDTH  word address
- mem_wdata  out  DATA_WIDTH  write data
- mem_sel  out  DATA_WIDTH/8  byte enables; all ones on reads
- mem_ack  in  1  request completed; read data valid on mem_rdata
- mem_rdata  in  DATA_WIDTH  read data

## Operation
- States: IDLE, READ, WRITE.
- IDLE: sample requests and pick one winner.
  - d_wr_en beats d_rd_en within the dcache port.
  - If only one port requests, it wins.
  - If both ports request, the port not granted last wins. rr_last resets to icache, so the dcache wins the first tie.
  - Read winner: latch {addr tag+index, offset=0} as base, clear word counter, go to READ.
  - Write winner: latch addr, data and sel, go to WRITE.
  - Update rr_last on every grant.
- READ:
  - mem_req=1, mem_we=0, mem_addr=base|count, mem_sel=all ones.
  - On mem_ack: route mem_rdata to the granted port's rd_data with its rd_valid=1 (combinational), and increment count.
  - After ack of word LINE_WIDTH-1, go to IDLE.
  - Words return in offset order 0..LINE_WIDTH-1.
  - rd_en changes during a burst are ignored.
  - The requester deasserts rd_en once it has received the last word. If rd_en is still high in IDLE, that is a new request.
- WRITE:
  - mem_req=1, mem_we=1, latched addr/data/sel driven.
  - On mem_ack: d_wr_rdy=1 for that cycle, go to IDLE.
- mem_req, mem_addr, mem_we, mem_wdata and mem_sel are stable from the start of a request until its ack.
- rd_data of the non-granted port is 0. rd_valid of the non-granted port is 0.
- Counter is OFFSET_WIDTH+1 bits wide. Addresses wrap only within the line (offset field); tag/index are never incremented.

## Timing
- Grant latency: a request seen in IDLE at edge N gives mem_req=1 in the cycle after edge N.
- mem_ack may arrive in the same cycle as mem_req (zero-wait memory) or any later cycle.
- Zero-wait refill: IDLE + LINE_WIDTH cycles, one word per cycle. The next request is sampled the cycle after the last ack.
- Zero-wait write: d_wr_rdy in the cycle after the grant edge.
- Reset values: state IDLE, count 0, rr_last icache, and all outputs 0, including mem_sel.
- Reset mid-burst or mid-write:
  - abort; mem_req=0 in the cycle after the reset edge;
  - no further rd_valid or wr_rdy;
  - a mem_ack arriving while in IDLE is ignored.
- A mem_ack in IDLE at any time is ignored.

## Structure
- Package mem_arb_pkg holds:
  - state encodings (S_IDLE=0, S_READ=1, S_WRITE=2);
  - port ids (PORT_I=0, PORT_D=1);
  - OFFSET_WIDTH derivation as a function of LINE_WIDTH.
- One sub-module, rr_arb2: two-way round-robin grant with last-grant register, inputs req[1:0] and advance, output one-hot gnt. Everything else stays in mem_arbiter.

## Test plan
- Lone icache refill:
  - Stimulus: i_rd_addr=0x1236, zero-wait memory.
  - Required: mem_addr 0x1234, 0x1235, 0x1236, 0x1237 on consecutive cycles; i_rd_valid ×4 with matching data; d_rd_valid never asserted.
- Dcache write:
  - Stimulus: addr 0x0040, data 0xDEADBEEF, sel 4'b0011; memory acks after 3 wait cycles.
  - Required: mem_we=1, fields stable for all 4 request cycles; d_wr_rdy a single pulse in the ack cycle.
- Simultaneous requests, same cycle after reset:
  - Stimulus: i_rd_en, d_rd_en and d_wr_en all asserted.
  - Required order: dcache write, then icache refill, then dcache refill.
- Back-to-back icache refills:
  - Stimulus: i_rd_en held high, d_rd_en held high.
  - Required: strict alternation of 4-word bursts between the two ports.
- Reset mid-burst:
  - Stimulus: rst asserted after the 2nd ack of a dcache refill, then a late mem_ack.
  - Required: mem_req=0 the next cycle; no further d_rd_valid; the late ack is ignored; a fresh request after reset starts at offset 0.
- Random wait states (0–5 cycles):
  - Stimulus: random refills and writes from both ports.
  - Required: scoreboard confirms every word's address and data and no lost or duplicated ack.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared encodings for the cache/memory arbiter
// Purpose: FSM state encodings, requester port ids and line-offset width helper.
// Ports: none (package).
package mem_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2
  } state_t;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  // Number of address bits that select a word within a cache line.
  function automatic int offset_width(input int line_width);
    return $clog2(line_width);
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// rtl/mem_arbiter_rr_arb2.sv - two-way round-robin grant with last-grant register
// Purpose: grants one of two requesters; on a tie the one not granted last wins.
// Ports:
//   clk, rst     - clock, synchronous active-high reset
//   req[1:0]     - request per port (bit 0 icache, bit 1 dcache)
//   advance      - a grant is being taken this cycle; record the winner
//   gnt[1:0]     - one-hot grant (combinational)
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  logic last_q;

  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = (last_q == PORT_I) ? 2'b10 : 2'b01;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= PORT_I;
    end else if (advance && (gnt != 2'b00)) begin
      last_q <= gnt[1];
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares one word-wide memory port between icache and dcache
// Purpose: turns line refills into LINE_WIDTH sequential word reads, forwards dcache
//          word writes, round-robin between caches, dcache writes ahead of dcache reads.
// Ports:
//   clk, rst                          - clock, synchronous active-high reset
//   i_rd_en/i_rd_addr                 - icache refill request and address
//   i_rd_data/i_rd_valid              - icache refill word return
//   d_rd_en/d_rd_addr                 - dcache refill request and address
//   d_rd_data/d_rd_valid              - dcache refill word return
//   d_wr_en/d_wr_addr/d_wr_data/d_wr_sel/d_wr_rdy - dcache word write handshake
//   mem_req/mem_we/mem_addr/mem_wdata/mem_sel     - memory request (held until mem_ack)
//   mem_ack/mem_rdata                 - memory completion and read data
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int LINE_WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_rd_en,
  input  logic [ADDR_WIDTH-1:0]   i_rd_addr,
  output logic [DATA_WIDTH-1:0]   i_rd_data,
  output logic                    i_rd_valid,
  input  logic                    d_rd_en,
  input  logic [ADDR_WIDTH-1:0]   d_rd_addr,
  output logic [DATA_WIDTH-1:0]   d_rd_data,
  output logic                    d_rd_valid,
  input  logic                    d_wr_en,
  input  logic [ADDR_WIDTH-1:0]   d_wr_addr,
  input  logic [DATA_WIDTH-1:0]   d_wr_data,
  input  logic [DATA_WIDTH/8-1:0] d_wr_sel,
  output logic                    d_wr_rdy,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_sel,
  input  logic                    mem_ack,
  input  logic [DATA_WIDTH-1:0]   mem_rdata
);

  localparam int OW = offset_width(LINE_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] OFF_MASK = ADDR_WIDTH'(LINE_WIDTH - 1);
  localparam logic [OW:0] LAST = (OW + 1)'(LINE_WIDTH - 1);

  state_t          state;
  logic [OW:0]     count;
  logic [OW:0]     count_inc;
  logic            port_q;
  logic [1:0]      gnt;
  logic [ADDR_WIDTH-1:0] rd_addr_sel;
  logic            rd_ack;

  rr_arb2 u_rr (
    .clk     (clk),
    .rst     (rst),
    .req     ({d_wr_en | d_rd_en, i_rd_en}),
    .advance (state == S_IDLE),
    .gnt     (gnt)
  );

  assign count_inc   = count + 1'b1;
  assign rd_addr_sel = gnt[PORT_D] ? d_rd_addr : i_rd_addr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      count     <= '0;
      port_q    <= PORT_I;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_sel   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (gnt[PORT_D] && d_wr_en) begin
            state     <= S_WRITE;
            port_q    <= PORT_D;
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= d_wr_addr;
            mem_wdata <= d_wr_data;
            mem_sel   <= d_wr_sel;
          end else if (gnt != 2'b00) begin
            state    <= S_READ;
            port_q   <= gnt[PORT_D];
            count    <= '0;
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= rd_addr_sel & ~OFF_MASK;
            mem_sel  <= '1;
          end
        end
        S_READ: begin
          if (mem_ack) begin
            count    <= count_inc;
            // Only the offset field advances; tag/index stay fixed.
            mem_addr <= (mem_addr & ~OFF_MASK) |
                        {{(ADDR_WIDTH-OW){1'b0}}, count_inc[OW-1:0]};
            if (count == LAST) begin
              state   <= S_IDLE;
              mem_req <= 1'b0;
            end
          end
        end
        S_WRITE: begin
          if (mem_ack) begin
            state   <= S_IDLE;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Acks are passed straight through; gated by rst so an abort yields no returns.
  assign rd_ack     = !rst && (state == S_READ) && mem_ack;
  assign i_rd_valid = rd_ack && (port_q == PORT_I);
  assign d_rd_valid = rd_ack && (port_q == PORT_D);
  assign i_rd_data  = i_rd_valid ? mem_rdata : '0;
  assign d_rd_data  = d_rd_valid ? mem_rdata : '0;
  assign d_wr_rdy   = !rst && (state == S_WRITE) && mem_ack;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_rd_en, d_rd_en, d_wr_en;
  logic [15:0] i_rd_addr, d_rd_addr, d_wr_addr;
  logic [31:0] i_rd_data, d_rd_data, d_wr_data;
  logic        i_rd_valid, d_rd_valid, d_wr_rdy;
  logic [3:0]  d_wr_sel, mem_sel;
  logic        mem_req, mem_we, mem_ack;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .LINE_WIDTH(4)) dut (
    .clk(clk), .rst(rst),
    .i_rd_en(i_rd_en), .i_rd_addr(i_rd_addr), .i_rd_data(i_rd_data), .i_rd_valid(i_rd_valid),
    .d_rd_en(d_rd_en), .d_rd_addr(d_rd_addr), .d_rd_data(d_rd_data), .d_rd_valid(d_rd_valid),
    .d_wr_en(d_wr_en), .d_wr_addr(d_wr_addr), .d_wr_data(d_wr_data), .d_wr_sel(d_wr_sel),
    .d_wr_rdy(d_wr_rdy),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_sel(mem_sel), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mdata(input logic [15:0] a);
    return {a ^ 16'h5A5A, ~a};
  endfunction

  // Memory model: acks after a number of wait cycles, read data derived from address.
  int  fixed_wait = 0;
  bit  rand_mode = 0;
  int  cur_rand = 0;
  int  wcnt = 0;
  bit  inject = 0;
  int  acks = 0;

  initial begin
    mem_ack = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #2;
      mem_ack = 1'b0;
      mem_rdata = '0;
      if (inject) begin
        mem_ack = 1'b1;
        mem_rdata = 32'hBAD0BAD0;
      end else if (mem_req && !rst) begin
        if (wcnt >= (rand_mode ? cur_rand : fixed_wait)) begin
          mem_ack = 1'b1;
          mem_rdata = mem_we ? 32'h0 : mdata(mem_addr);
          wcnt = 0;
          acks++;
          cur_rand = $urandom_range(0, 5);
        end else begin
          wcnt++;
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  // Scoreboard state per requester.
  logic [15:0] i_base, d_base, w_addr;
  logic [31:0] w_data;
  logic [3:0]  w_sel;
  int  i_got = 0, d_got = 0;
  bit  i_active = 0, d_active = 0, w_active = 0, w_done = 0;
  int  events = 0;
  int  order_q[$];
  bit  prev_pend = 0;
  logic [53:0] prev_bus;

  always @(negedge clk) begin
    if (!rst) begin
      if (mem_ack || i_rd_valid || d_rd_valid || d_wr_rdy)
        check("ack_route_count", 32'(i_rd_valid) + 32'(d_rd_valid) + 32'(d_wr_rdy),
              (mem_ack && !inject) ? 1 : 0);
      if (prev_pend)
        check("req_stable", {mem_req, mem_we, mem_addr, mem_wdata, mem_sel}, prev_bus);
      if (mem_ack && !i_rd_valid) check("i_idle_data", i_rd_data, 0);
      if (mem_ack && !d_rd_valid) check("d_idle_data", d_rd_data, 0);
      if (i_rd_valid) begin
        events++;
        if (!i_active || i_got >= 4) check("i_unexpected_valid", 1, 0);
        else begin
          if (i_got == 0) order_q.push_back(0);
          check("i_addr", mem_addr, i_base | 16'(i_got));
          check("i_data", i_rd_data, mdata(i_base | 16'(i_got)));
          check("i_rd_sel", {mem_we, mem_sel}, 5'b0_1111);
          i_got++;
        end
      end
      if (d_rd_valid) begin
        events++;
        if (!d_active || d_got >= 4) check("d_unexpected_valid", 1, 0);
        else begin
          if (d_got == 0) order_q.push_back(1);
          check("d_addr", mem_addr, d_base | 16'(d_got));
          check("d_data", d_rd_data, mdata(d_base | 16'(d_got)));
          d_got++;
        end
      end
      if (d_wr_rdy) begin
        events++;
        if (!w_active || w_done) check("w_unexpected_rdy", 1, 0);
        else begin
          order_q.push_back(2);
          check("w_fields", {mem_we, mem_addr, mem_wdata, mem_sel}, {1'b1, w_addr, w_data, w_sel});
          w_done = 1;
        end
      end
    end
    prev_pend = mem_req && !mem_ack && !rst;
    prev_bus  = {mem_req, mem_we, mem_addr, mem_wdata, mem_sel};
  end

  task automatic do_iread(input logic [15:0] addr, input logic [15:0] base, output int cyc);
    i_base = base; i_got = 0; i_active = 1;
    i_rd_addr = addr; i_rd_en = 1'b1; cyc = 0;
    while (i_got < 4 && cyc < 400) begin @(posedge clk); #1; cyc++; end
    i_rd_en = 1'b0; i_active = 0;
    check("i_words", i_got, 4);
  endtask

  task automatic do_dread(input logic [15:0] addr, input logic [15:0] base, output int cyc);
    d_base = base; d_got = 0; d_active = 1;
    d_rd_addr = addr; d_rd_en = 1'b1; cyc = 0;
    while (d_got < 4 && cyc < 400) begin @(posedge clk); #1; cyc++; end
    d_rd_en = 1'b0; d_active = 0;
    check("d_words", d_got, 4);
  endtask

  task automatic do_dwrite(input logic [15:0] addr, input logic [31:0] data,
                           input logic [3:0] sel, output int cyc);
    w_addr = addr; w_data = data; w_sel = sel; w_done = 0; w_active = 1;
    d_wr_addr = addr; d_wr_data = data; d_wr_sel = sel; d_wr_en = 1'b1; cyc = 0;
    while (!w_done && cyc < 400) begin @(posedge clk); #1; cyc++; end
    d_wr_en = 1'b0; w_active = 0;
    check("w_done", w_done, 1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    i_rd_en = 0; d_rd_en = 0; d_wr_en = 0;
    i_rd_addr = 0; d_rd_addr = 0; d_wr_addr = 0; d_wr_data = 0; d_wr_sel = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    order_q.delete();
  endtask

  typedef struct {
    int          kind;   // 0 icache refill, 1 dcache refill, 2 dcache write
    logic [15:0] addr;
    logic [31:0] data;
    logic [3:0]  sel;
    int          wt;
    logic [15:0] base;
    int          cyc;    // cycles from request to completion
  } vec_t;

  vec_t vecs[7];

  initial begin
    int cyc, c1, c2, c3;
    int exp_alt[6];

    vecs[0] = '{0, 16'h1236, 32'h0,        4'h0, 0, 16'h1234, 5};
    vecs[1] = '{2, 16'h0040, 32'hDEADBEEF, 4'h3, 3, 16'h0040, 5};
    vecs[2] = '{1, 16'hABCF, 32'h0,        4'h0, 0, 16'hABCC, 5};
    vecs[3] = '{0, 16'hFFFF, 32'h0,        4'h0, 1, 16'hFFFC, 9};
    vecs[4] = '{1, 16'h0003, 32'h0,        4'h0, 2, 16'h0000, 13};
    vecs[5] = '{2, 16'h7FFE, 32'h12345678, 4'hF, 0, 16'h7FFE, 2};
    vecs[6] = '{0, 16'h0000, 32'h0,        4'h0, 0, 16'h0000, 5};
    exp_alt = '{1, 0, 1, 0, 1, 0};

    do_reset();
    check("rst_bus", {mem_req, mem_we, mem_addr, mem_wdata, mem_sel}, 54'h0);
    check("rst_ret", {i_rd_valid, d_rd_valid, d_wr_rdy, i_rd_data, d_rd_data}, 67'h0);

    for (int k = 0; k < 7; k++) begin
      fixed_wait = vecs[k].wt;
      case (vecs[k].kind)
        0:       do_iread(vecs[k].addr, vecs[k].base, cyc);
        1:       do_dread(vecs[k].addr, vecs[k].base, cyc);
        default: do_dwrite(vecs[k].addr, vecs[k].data, vecs[k].sel, cyc);
      endcase
      check($sformatf("vec%0d_cycles", k), cyc, vecs[k].cyc);
      @(posedge clk); #1;
    end
    fixed_wait = 0;

    // All three requests in the first cycle after reset.
    do_reset();
    fork
      do_dwrite(16'h0040, 32'hCAFEF00D, 4'hF, c1);
      do_iread(16'h0302, 16'h0300, c2);
      do_dread(16'h0405, 16'h0404, c3);
    join
    check("sim_order_len", order_q.size(), 3);
    if (order_q.size() == 3) begin
      check("sim_order0", order_q[0], 2);
      check("sim_order1", order_q[1], 0);
      check("sim_order2", order_q[2], 1);
    end

    // Both refill ports held busy: bursts must alternate, dcache first.
    do_reset();
    fork
      for (int k = 0; k < 3; k++) do_iread(16'h0101 + 16'(k * 8), 16'h0100 + 16'(k * 8), c1);
      for (int k = 0; k < 3; k++) do_dread(16'h0202 + 16'(k * 8), 16'h0200 + 16'(k * 8), c2);
    join
    check("alt_order_len", order_q.size(), 6);
    if (order_q.size() == 6)
      for (int k = 0; k < 6; k++) check($sformatf("alt_order%0d", k), order_q[k], exp_alt[k]);

    // Reset after the second word of a dcache refill, then a stray ack in IDLE.
    do_reset();
    d_base = 16'h2004; d_got = 0; d_active = 1;
    d_rd_addr = 16'h2005; d_rd_en = 1'b1; cyc = 0;
    while (d_got < 2 && cyc < 100) begin @(posedge clk); #1; cyc++; end
    check("abort_reached", d_got, 2);
    rst = 1'b1; d_rd_en = 1'b0;
    @(posedge clk); #1;
    check("abort_req_low", {mem_req, d_rd_valid}, 2'b00);
    rst = 1'b0;
    inject = 1;
    @(posedge clk); #1;
    inject = 0;
    check("late_ack_ignored", {mem_req, mem_we}, 2'b00);
    check("abort_no_more", d_got, 2);
    d_active = 0;
    do_dread(16'h2005, 16'h2004, cyc);
    check("after_abort_cycles", cyc, 5);

    // Random wait states and mixed traffic.
    do_reset();
    rand_mode = 1;
    fork
      for (int k = 0; k < 5; k++) begin
        logic [15:0] a;
        a = 16'($urandom);
        do_iread(a, a & 16'hFFFC, c1);
      end
      for (int k = 0; k < 6; k++) begin
        logic [15:0] a;
        a = 16'($urandom);
        if ($urandom_range(0, 1) == 1) do_dwrite(a, $urandom, 4'($urandom), c2);
        else do_dread(a, a & 16'hFFFC, c2);
      end
    join
    rand_mode = 0;
    check("ack_vs_returns", acks, events);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
